cache_control: RTL and testbench
================================

Name: cache_control

Overview:
Moore/Mealy FSM that sequences the 2-way set-associative write-back cache datapath (tag/valid/dirty/LRU/data arrays, pmem address mux, writeback buffer). It takes CPU requests (mem_read/mem_write) and drives every array read/load strobe and mux select. It also runs the physical-memory handshake for dirty-victim writeback and line fill. It sits between the CPU memory port and the cache datapath, with one instance per cache.

Parameters:
s_offset, 5, byte-offset bits per 256-bit line
s_mask, 32, bytes per line (2**s_offset); width of per-way data write mask

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable  in  4  CPU byte enables for the addressed word
mem_address  in  32  CPU address; only [4:2] used here
mem_resp  out  1  one-cycle request completion
pmem_read  out  1  line fill request, held until pmem_resp
pmem_write  out  1  line writeback request, held until pmem_resp
pmem_resp  in  1  physical memory done
hit1, hit2  in  1 each  way tag-match-and-valid
dirty_out1, dirty_out2  in  1 each  way dirty bits
valid_out1, valid_out2  in  1 each  way valid bits
lru_out  in  1  way to evict next (0=way1, 1=way2)
array_read  out  1  read strobe to all tag/valid/dirty/data arrays
data_w1, data_w2  out  s_mask  per-way byte write enables
load_tag1, load_tag2, load_valid1, load_valid2, load_dirty1, load_dirty2  out  1 each  array loads
load_lru  out  1  LRU array load
valid_in, dirty_in, lru_in  out  1 each  array write data
data_sel  out  1  0=pmem_rdata, 1=merged CPU write line
path_sel  out  1  0=way1, 1=way2 output mux
pmem_sel  out  2  00=CPU line address, 01=way1 tag address, 10=way2 tag address
load_pmem_wdata  out  1  capture victim line into writeback register

Behaviour:
- States: IDLE, CHECK, WRITEBACK, FILL. State and victim_q are registered; outputs decode combinationally from state, victim_q and inputs.
- Reset: state=IDLE, victim_q=0. With no request, every output is 0.
- Request qualifier: req = mem_read | mem_write. If both are asserted, the request is treated as a write.
- IDLE: array_read=req. If req, go to CHECK. Arrays are synchronous-read, so their outputs are valid in CHECK.
- CHECK, hit (hit1 | hit2; hit1 wins if both): mem_resp=1. path_sel selects the hit way. load_lru=1 with lru_in = the other way. Go to IDLE.
- CHECK, write hit: additionally data_sel=1, data_wN = {28'b0, mem_byte_enable} << (4*mem_address[4:2]) on the hit way, load_dirtyN=1, dirty_in=1.
- CHECK, miss: victim_q <= lru_out.
  - If victim valid & dirty: path_sel=lru_out, load_pmem_wdata=1, go to WRITEBACK.
  - Else go to FILL.
  - mem_resp=0.
- WRITEBACK: pmem_write=1. pmem_sel=01 (victim_q=0) or 10 (victim_q=1). On pmem_resp, go to FILL. Otherwise stay.
- FILL: pmem_read=1, pmem_sel=00. On pmem_resp, write into the victim way and go to CHECK:
  - data_sel=0, data_w(victim) = all ones;
  - load_tag, load_valid (valid_in=1), load_dirty (dirty_in=0).
- After FILL, CHECK re-reads the arrays and must hit. A write miss completes its merge in that CHECK cycle.
- Latency:
  - hit: mem_resp on the 2nd cycle after req is seen;
  - clean miss: 2 + fill latency + 1;
  - dirty miss adds the writeback latency.
- pmem_read and pmem_write are never asserted together. Each is held steady until pmem_resp. A pmem_resp outside WRITEBACK/FILL is ignored.
- rst mid-operation: returns to IDLE on the next edge. Any pending pmem request drops immediately, and no array load occurs on the reset cycle.
- mem_resp is exactly one cycle. A request still asserted in the cycle after mem_resp is a new request.

Decomposition:
- Package cache_types holds:
  - enum cache_state_t {IDLE, CHECK, WRITEBACK, FILL};
  - PMEM_SEL_CPU=2'b00, PMEM_SEL_WAY1=2'b01, PMEM_SEL_WAY2=2'b10;
  - DATA_SEL_PMEM=1'b0, DATA_SEL_CPU=1'b1.
- One sub-module, cache_wmask_gen: combinational byte_enable/offset to 32-bit line mask.

Test Plan:
- Read hit: way2 valid with tag match, mem_read at 0x0000_0124 -> mem_resp in 2nd cycle, path_sel=1, load_lru=1, lru_in=0, no pmem activity.
- Write hit: mem_byte_enable=4'b0011, addr[4:2]=3'd5, hit1 -> data_w1=32'h0030_0000, dirty_in=1, load_dirty1=1, mem_resp=1.
- Clean miss: lru_out=1, way2 invalid, pmem_resp after 5 cycles -> pmem_read for 5 cycles with pmem_sel=00, then data_w2=all ones, load_tag2/valid2, then CHECK hit, mem_resp.
- Dirty miss: lru_out=0, way1 valid+dirty -> load_pmem_wdata pulse, pmem_write with pmem_sel=01 until pmem_resp, then FILL, then mem_resp; pmem_read and pmem_write never overlap.
- Reset in FILL: assert rst while pmem_read=1 -> next cycle state IDLE, all outputs 0, no tag/valid load.
- Simultaneous mem_read & mem_write on a hit -> handled as a write (data_w nonzero, dirty set).

Source files
------------

// File: rtl/cache_types.sv
// ---------------------------------------------------------------------------
// cache_types
// Shared types and encodings for the 2-way write-back cache controller:
//   cache_state_t  : controller FSM states
//   PMEM_SEL_*     : physical-memory address mux selects
//   DATA_SEL_*     : data-array write source selects
// ---------------------------------------------------------------------------
package cache_types;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHECK     = 2'd1,
      WRITEBACK = 2'd2,
      FILL      = 2'd3
   } cache_state_t;

   localparam logic [1:0] PMEM_SEL_CPU  = 2'b00;
   localparam logic [1:0] PMEM_SEL_WAY1 = 2'b01;
   localparam logic [1:0] PMEM_SEL_WAY2 = 2'b10;

   localparam logic DATA_SEL_PMEM = 1'b0;
   localparam logic DATA_SEL_CPU  = 1'b1;

endpackage

// File: rtl/cache_wmask_gen.sv
// ---------------------------------------------------------------------------
// cache_wmask_gen
// Expands a CPU word byte-enable into a per-byte write mask for a full line.
//   i_byte_enable : byte enables of the addressed 32-bit word
//   i_word        : word index within the line (address bits [s_offset-1:2])
//   o_mask        : s_mask-bit byte write mask, enables placed at the word
// ---------------------------------------------------------------------------
module cache_wmask_gen #(
   parameter int s_offset = 5,
   parameter int s_mask   = 32
) (
   input  logic [3:0]          i_byte_enable,
   input  logic [s_offset-3:0] i_word,
   output logic [s_mask-1:0]   o_mask
);

   logic [s_mask-1:0] w_base;

   assign w_base = {{(s_mask-4){1'b0}}, i_byte_enable};
   assign o_mask = w_base << {i_word, 2'b00};

endmodule

// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
// Sequencer for a 2-way set-associative write-back cache datapath.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   mem_read/mem_write/...    : CPU request port, mem_resp one-cycle done
//   pmem_read/pmem_write/resp : physical-memory handshake (writeback / fill)
//   hit*, dirty_out*, valid_out*, lru_out : array status from the datapath
//   array_read, data_w*, load_*, *_in     : array strobes and write data
//   data_sel, path_sel, pmem_sel          : datapath mux selects
//   load_pmem_wdata           : capture the victim line for writeback
// State and victim way are registered; all outputs decode combinationally.
// ---------------------------------------------------------------------------
module cache_control
   import cache_types::*;
#(
   parameter int s_offset = 5,
   parameter int s_mask   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [3:0]        mem_byte_enable,
   input  logic [31:0]       mem_address,
   output logic              mem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   input  logic              pmem_resp,
   input  logic              hit1,
   input  logic              hit2,
   input  logic              dirty_out1,
   input  logic              dirty_out2,
   input  logic              valid_out1,
   input  logic              valid_out2,
   input  logic              lru_out,
   output logic              array_read,
   output logic [s_mask-1:0] data_w1,
   output logic [s_mask-1:0] data_w2,
   output logic              load_tag1,
   output logic              load_tag2,
   output logic              load_valid1,
   output logic              load_valid2,
   output logic              load_dirty1,
   output logic              load_dirty2,
   output logic              load_lru,
   output logic              valid_in,
   output logic              dirty_in,
   output logic              lru_in,
   output logic              data_sel,
   output logic              path_sel,
   output logic [1:0]        pmem_sel,
   output logic              load_pmem_wdata
);

   cache_state_t r_state;
   logic         r_victim;

   logic              w_req;
   logic              w_hit;
   logic              w_hit_way;      // 0=way1, 1=way2; way1 wins on double hit
   logic              w_victim_dirty;
   logic [s_mask-1:0] w_wmask;
   logic              w_unused;

   assign w_req          = mem_read | mem_write;
   assign w_hit          = hit1 | hit2;
   assign w_hit_way      = ~hit1;
   assign w_victim_dirty = lru_out ? (valid_out2 & dirty_out2)
                                   : (valid_out1 & dirty_out1);
   assign w_unused       = &{1'b0, mem_address[31:s_offset], mem_address[1:0]};

   cache_wmask_gen #(
      .s_offset (s_offset),
      .s_mask   (s_mask)
   ) u_wmask (
      .i_byte_enable (mem_byte_enable),
      .i_word        (mem_address[s_offset-1:2]),
      .o_mask        (w_wmask)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_victim <= 1'b0;
      end else begin
         case (r_state)
            IDLE:      if (w_req) r_state <= CHECK;
            CHECK: begin
               if (w_hit) begin
                  r_state <= IDLE;
               end else begin
                  r_victim <= lru_out;
                  r_state  <= w_victim_dirty ? WRITEBACK : FILL;
               end
            end
            WRITEBACK: if (pmem_resp) r_state <= FILL;
            FILL:      if (pmem_resp) r_state <= CHECK;
            default:   r_state <= IDLE;
         endcase
      end
   end

   // Outputs are forced low while rst is high so a reset mid-transfer
   // drops the pmem request and suppresses any array load that cycle.
   always_comb begin
      mem_resp        = 1'b0;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      array_read      = 1'b0;
      data_w1         = '0;
      data_w2         = '0;
      load_tag1       = 1'b0;
      load_tag2       = 1'b0;
      load_valid1     = 1'b0;
      load_valid2     = 1'b0;
      load_dirty1     = 1'b0;
      load_dirty2     = 1'b0;
      load_lru        = 1'b0;
      valid_in        = 1'b0;
      dirty_in        = 1'b0;
      lru_in          = 1'b0;
      data_sel        = DATA_SEL_PMEM;
      path_sel        = 1'b0;
      pmem_sel        = PMEM_SEL_CPU;
      load_pmem_wdata = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: array_read = w_req;
            CHECK: begin
               if (w_hit) begin
                  mem_resp = 1'b1;
                  path_sel = w_hit_way;
                  load_lru = 1'b1;
                  lru_in   = ~w_hit_way;
                  // mem_write dominates, so read+write is handled as a write
                  if (mem_write) begin
                     data_sel = DATA_SEL_CPU;
                     dirty_in = 1'b1;
                     if (w_hit_way) begin
                        data_w2     = w_wmask;
                        load_dirty2 = 1'b1;
                     end else begin
                        data_w1     = w_wmask;
                        load_dirty1 = 1'b1;
                     end
                  end
               end else if (w_victim_dirty) begin
                  path_sel        = lru_out;
                  load_pmem_wdata = 1'b1;
               end
            end
            WRITEBACK: begin
               pmem_write = 1'b1;
               pmem_sel   = r_victim ? PMEM_SEL_WAY2 : PMEM_SEL_WAY1;
            end
            FILL: begin
               pmem_read = 1'b1;
               pmem_sel  = PMEM_SEL_CPU;
               if (pmem_resp) begin
                  // strobe the arrays so the following CHECK sees the new line
                  array_read = 1'b1;
                  data_sel   = DATA_SEL_PMEM;
                  valid_in   = 1'b1;
                  dirty_in   = 1'b0;
                  if (r_victim) begin
                     data_w2     = '1;
                     load_tag2   = 1'b1;
                     load_valid2 = 1'b1;
                     load_dirty2 = 1'b1;
                  end else begin
                     data_w1     = '1;
                     load_tag1   = 1'b1;
                     load_valid1 = 1'b1;
                     load_dirty1 = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: inputs change on the falling edge and
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_cache_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic        mem_resp, pmem_read, pmem_write, pmem_resp;
   logic        hit1, hit2, dirty_out1, dirty_out2, valid_out1, valid_out2, lru_out;
   logic        array_read;
   logic [31:0] data_w1, data_w2;
   logic        load_tag1, load_tag2, load_valid1, load_valid2, load_dirty1, load_dirty2;
   logic        load_lru, valid_in, dirty_in, lru_in, data_sel, path_sel;
   logic [1:0]  pmem_sel;
   logic        load_pmem_wdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cache_control #(.s_offset(5), .s_mask(32)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_resp(pmem_resp),
      .hit1(hit1), .hit2(hit2), .dirty_out1(dirty_out1), .dirty_out2(dirty_out2),
      .valid_out1(valid_out1), .valid_out2(valid_out2), .lru_out(lru_out),
      .array_read(array_read), .data_w1(data_w1), .data_w2(data_w2),
      .load_tag1(load_tag1), .load_tag2(load_tag2),
      .load_valid1(load_valid1), .load_valid2(load_valid2),
      .load_dirty1(load_dirty1), .load_dirty2(load_dirty2),
      .load_lru(load_lru), .valid_in(valid_in), .dirty_in(dirty_in), .lru_in(lru_in),
      .data_sel(data_sel), .path_sel(path_sel), .pmem_sel(pmem_sel),
      .load_pmem_wdata(load_pmem_wdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clr_status();
      hit1 = 0; hit2 = 0; dirty_out1 = 0; dirty_out2 = 0;
      valid_out1 = 0; valid_out2 = 0; lru_out = 0;
   endtask

   // All CPU-visible and pmem-handshake outputs at once, bit-packed.
   function automatic logic [31:0] ctl_bits();
      return {18'b0, mem_resp, pmem_read, pmem_write, array_read, load_tag1,
              load_tag2, load_valid1, load_valid2, load_dirty1, load_dirty2,
              load_lru, load_pmem_wdata, pmem_sel};
   endfunction

   initial begin
      rst = 1; mem_read = 0; mem_write = 0; mem_byte_enable = 4'h0;
      mem_address = 32'h0; pmem_resp = 0;
      clr_status();

      // ---- reset state
      @(negedge clk); #1;
      chk("reset_ctl", ctl_bits(), 32'h0);
      chk("reset_dw1", data_w1, 32'h0);
      @(negedge clk); mem_read = 1; #1;
      chk("reset_gates_req", {31'b0, array_read}, 32'h0);
      @(negedge clk); rst = 0; mem_read = 0;

      // ---- stray pmem_resp in IDLE is ignored
      @(negedge clk); pmem_resp = 1; #1;
      chk("idle_stray_resp", ctl_bits(), 32'h0);
      @(negedge clk); pmem_resp = 0;

      // ---- read hit on way2
      mem_read = 1; mem_address = 32'h0000_0124; #1;
      chk("rh_idle_aread", {31'b0, array_read}, 32'd1);
      chk("rh_idle_resp", {31'b0, mem_resp}, 32'd0);
      @(negedge clk); hit2 = 1; valid_out2 = 1; #1;
      chk("rh_resp", {31'b0, mem_resp}, 32'd1);
      chk("rh_path", {31'b0, path_sel}, 32'd1);
      chk("rh_lru", {30'b0, load_lru, lru_in}, 32'b10);
      chk("rh_no_pmem", {30'b0, pmem_read, pmem_write}, 32'd0);
      chk("rh_no_dw2", data_w2, 32'h0);
      @(negedge clk); mem_read = 0; clr_status(); #1;
      chk("rh_after", ctl_bits(), 32'h0);

      // ---- write hit on way1; request held past mem_resp is a new request
      @(negedge clk); mem_write = 1; mem_byte_enable = 4'b0011; mem_address = 32'h0000_0014;
      @(negedge clk); hit1 = 1; valid_out1 = 1; #1;
      chk("wh_dw1", data_w1, 32'h0030_0000);
      chk("wh_dw2", data_w2, 32'h0);
      chk("wh_dirty", {29'b0, load_dirty1, load_dirty2, dirty_in}, 32'b101);
      chk("wh_resp_sel", {29'b0, mem_resp, data_sel, path_sel}, 32'b110);
      chk("wh_lru_in", {31'b0, lru_in}, 32'd1);
      @(negedge clk); #1;
      chk("wh_resp_1cyc", {31'b0, mem_resp}, 32'd0);
      chk("wh_new_req", {31'b0, array_read}, 32'd1);
      @(negedge clk); #1;
      chk("wh2_resp", {31'b0, mem_resp}, 32'd1);
      @(negedge clk); mem_write = 0; clr_status();

      // ---- read+write together on a hit: treated as a write
      @(negedge clk); mem_read = 1; mem_write = 1; mem_byte_enable = 4'b1000;
      mem_address = 32'h0000_001C;
      @(negedge clk); hit1 = 1; hit2 = 1; valid_out1 = 1; valid_out2 = 1; #1;
      chk("rw_dw1", data_w1, 32'h8000_0000);
      chk("rw_dirty", {30'b0, load_dirty1, dirty_in}, 32'b11);
      chk("rw_sel", {30'b0, data_sel, path_sel}, 32'b10);
      @(negedge clk); mem_read = 0; mem_write = 0; clr_status();

      // ---- clean miss: victim way2 invalid, fill takes 5 cycles
      @(negedge clk); mem_read = 1; mem_address = 32'h0000_0240; lru_out = 1;
      @(negedge clk); #1;
      chk("cm_check", ctl_bits(), 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("cm_fill", ctl_bits(), 32'h0000_1000);
         chk("cm_fill_dw2", data_w2, 32'h0);
      end
      @(negedge clk); pmem_resp = 1; #1;
      chk("cm_fill_last", {29'b0, pmem_read, pmem_write, data_sel}, 32'b100);
      chk("cm_dw2", data_w2, 32'hFFFF_FFFF);
      chk("cm_dw1", data_w1, 32'h0);
      chk("cm_loads", {25'b0, load_tag1, load_tag2, load_valid1, load_valid2,
                       load_dirty2, valid_in, dirty_in}, 32'b0101110);
      @(negedge clk); pmem_resp = 0; hit2 = 1; valid_out2 = 1; #1;
      chk("cm_resp", {29'b0, mem_resp, pmem_read, path_sel}, 32'b101);
      @(negedge clk); mem_read = 0; clr_status();

      // ---- dirty write miss: victim way1, writeback 3 cycles, fill 2 cycles
      @(negedge clk); mem_write = 1; mem_byte_enable = 4'hF; mem_address = 32'h0000_0380;
      lru_out = 0; valid_out1 = 1; dirty_out1 = 1;
      @(negedge clk); #1;
      chk("dm_check", ctl_bits(), 32'h0000_0004);
      chk("dm_check_dw1", data_w1, 32'h0);
      @(negedge clk); clr_status(); #1;
      chk("dm_wb", ctl_bits(), 32'h0000_0801);
      @(negedge clk); #1;
      chk("dm_wb2", ctl_bits(), 32'h0000_0801);
      @(negedge clk); pmem_resp = 1; #1;
      chk("dm_wb3", ctl_bits(), 32'h0000_0801);
      @(negedge clk); pmem_resp = 0; #1;
      chk("dm_fill", ctl_bits(), 32'h0000_1000);
      @(negedge clk); pmem_resp = 1; #1;
      chk("dm_fill_dw1", data_w1, 32'hFFFF_FFFF);
      chk("dm_fill_ld", {28'b0, load_tag1, load_valid1, load_dirty1, dirty_in}, 32'b1110);
      @(negedge clk); pmem_resp = 0; hit1 = 1; valid_out1 = 1; #1;
      chk("dm_merge_dw1", data_w1, 32'h0000_000F);
      chk("dm_resp", {28'b0, mem_resp, data_sel, load_dirty1, dirty_in}, 32'b1111);
      @(negedge clk); mem_write = 0; clr_status();

      // ---- reset while filling
      @(negedge clk); mem_read = 1; mem_address = 32'h0000_0400; lru_out = 0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("rf_fill", {31'b0, pmem_read}, 32'd1);
      @(negedge clk); rst = 1; pmem_resp = 1; #1;
      chk("rf_drop", ctl_bits(), 32'h0);
      chk("rf_no_dw1", data_w1, 32'h0);
      @(negedge clk); rst = 0; pmem_resp = 0; mem_read = 0; #1;
      chk("rf_idle", ctl_bits(), 32'h0);
      @(negedge clk); mem_read = 1; #1;
      chk("rf_idle_req", {30'b0, array_read, pmem_read}, 32'b10);
      @(negedge clk); hit1 = 1; valid_out1 = 1; #1;
      chk("rf_hit_resp", {31'b0, mem_resp}, 32'd1);
      @(negedge clk); mem_read = 0; clr_status();

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
